// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle instruction sequencer.
// Walks FETCH -> DECODE -> EXECUTE -> (UNIT_WAIT) -> WRITE_BACK. Illegal
// instructions and misaligned control-flow targets go through TRAP.
// Optional feature: define MC_SEQ_INSTRET_EN to add the 64-bit retired
// instruction counter output 'instret'.
//
// Unit handshake: in the single EXECUTE cycle unit_start pulses with the
// decoder's unit_req mask and that mask is latched. A launched unit holds its
// unit_busy bit high while working. UNIT_WAIT lasts at least one cycle and
// exits in the first cycle where no launched unit reports busy. Busy bits of
// units that were not launched are ignored.
module mc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h100),
  parameter int              N_UNITS  = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        ir,
  input  logic               dec_illegal,
  input  logic [N_UNITS-1:0] unit_req,
  output logic [N_UNITS-1:0] unit_start,
  input  logic [N_UNITS-1:0] unit_busy,
  input  logic               jal_jump,
  input  logic               jalr_jump,
  input  logic               take_branch,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    jalr_base,
  output logic               exec_en,
  output logic               wb_en,
  output logic [XLEN-1:0]    pc,
  output logic [2:0]         state,
  output logic               trap_taken,
  output logic [XLEN-1:0]    mepc,
  output logic [3:0]         mcause
`ifdef MC_SEQ_INSTRET_EN
  ,
  output logic [63:0]        instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'b000,
    S_DECODE     = 3'b001,
    S_EXECUTE    = 3'b010,
    S_WRITE_BACK = 3'b011,
    S_UNIT_WAIT  = 3'b100,
    S_TRAP       = 3'b101
  } state_t;

  localparam logic [31:0]     NOP_INSTR   = 32'h0000_0013;
  localparam logic [3:0]      CAUSE_MISAL = 4'd0;
  localparam logic [3:0]      CAUSE_ILL   = 4'd2;
  localparam logic [XLEN-1:0] BIT0_CLEAR  = ~XLEN'(1);

  state_t             state_q;
  logic [N_UNITS-1:0] launch_mask;
  logic [XLEN-1:0]    npc_q;
  logic [3:0]         trap_code;

  logic [XLEN-1:0]    jalr_sum;
  logic [XLEN-1:0]    target;
  logic               cf_sel;
  logic               misaligned;

  // Next-PC selection and misaligned control-flow target detection
  always_comb begin
    jalr_sum = jalr_base + imm;
    cf_sel   = jalr_jump | jal_jump | take_branch;
    if (jalr_jump) begin
      target = jalr_sum & BIT0_CLEAR;
    end else if (jal_jump || take_branch) begin
      target = pc + imm;
    end else begin
      target = pc + XLEN'(4);
    end
    misaligned = cf_sel & target[1];
  end

  // State-decoded strobes; fetch request is suppressed while reset is held
  always_comb begin
    imem_req   = reset && (state_q == S_FETCH);
    exec_en    = (state_q == S_EXECUTE);
    wb_en      = (state_q == S_WRITE_BACK);
    trap_taken = (state_q == S_TRAP);
    unit_start = ((state_q == S_EXECUTE) && !misaligned) ? unit_req : '0;
  end

  assign imem_addr = pc;
  assign state     = state_q;

  // Sequencer FSM and architectural state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= NOP_INSTR;
      mepc        <= '0;
      mcause      <= '0;
      launch_mask <= '0;
      npc_q       <= '0;
      trap_code   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            ir      <= imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            trap_code <= CAUSE_ILL;
            state_q   <= S_TRAP;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          npc_q <= target;
          if (misaligned) begin
            trap_code <= CAUSE_MISAL;
            state_q   <= S_TRAP;
          end else if (unit_req != '0) begin
            launch_mask <= unit_req;
            state_q     <= S_UNIT_WAIT;
          end else begin
            state_q <= S_WRITE_BACK;
          end
        end
        S_UNIT_WAIT: begin
          if ((unit_busy & launch_mask) == '0) begin
            launch_mask <= '0;
            state_q     <= S_WRITE_BACK;
          end
        end
        S_WRITE_BACK: begin
          pc      <= npc_q;
          state_q <= S_FETCH;
        end
        S_TRAP: begin
          mepc    <= pc;
          mcause  <= trap_code;
          pc      <= TRAP_VEC;
          state_q <= S_FETCH;
        end
        default: begin
          // Unused encodings recover through a trap
          trap_code <= CAUSE_MISAL;
          state_q   <= S_TRAP;
        end
      endcase
    end
  end

`ifdef MC_SEQ_INSTRET_EN
  // Retired-instruction counter: one count per WRITE_BACK, wraps at 2^64
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret <= '0;
    end else if (state_q == S_WRITE_BACK) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed and randomized instruction streams for
// mc_sequencer, compared against an instruction-level reference model.
module tb_mc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] TRAP_VEC = 32'h100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        dec_illegal;
  logic [1:0]  unit_req;
  logic [1:0]  unit_start;
  logic [1:0]  unit_busy;
  logic        jal_jump;
  logic        jalr_jump;
  logic        take_branch;
  logic [31:0] imm;
  logic [31:0] jalr_base;
  logic        exec_en;
  logic        wb_en;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        trap_taken;
  logic [31:0] mepc;
  logic [3:0]  mcause;
`ifdef MC_SEQ_INSTRET_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] exp_pc;
  logic [31:0] exp_ir;
  logic [31:0] exp_mepc;
  logic [3:0]  exp_mcause;
  logic [63:0] exp_instret;

  mc_sequencer #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC),
    .N_UNITS  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .dec_illegal (dec_illegal),
    .unit_req    (unit_req),
    .unit_start  (unit_start),
    .unit_busy   (unit_busy),
    .jal_jump    (jal_jump),
    .jalr_jump   (jalr_jump),
    .take_branch (take_branch),
    .imm         (imm),
    .jalr_base   (jalr_base),
    .exec_en     (exec_en),
    .wb_en       (wb_en),
    .pc          (pc),
    .state       (state),
    .trap_taken  (trap_taken),
    .mepc        (mepc),
    .mcause      (mcause)
`ifdef MC_SEQ_INSTRET_EN
    ,
    .instret     (instret)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input string w, input logic r, input logic e, input logic wb,
                         input logic t, input logic [1:0] us);
    chk({w, ".imem_req"},   64'(imem_req),   64'(r));
    chk({w, ".exec_en"},    64'(exec_en),    64'(e));
    chk({w, ".wb_en"},      64'(wb_en),      64'(wb));
    chk({w, ".trap_taken"}, 64'(trap_taken), 64'(t));
    chk({w, ".unit_start"}, 64'(unit_start), 64'(us));
  endtask

  task automatic arch(input string w);
    chk({w, ".pc"},     64'(pc),     64'(exp_pc));
    chk({w, ".ir"},     64'(ir),     64'(exp_ir));
    chk({w, ".mepc"},   64'(mepc),   64'(exp_mepc));
    chk({w, ".mcause"}, 64'(mcause), 64'(exp_mcause));
`ifdef MC_SEQ_INSTRET_EN
    chk({w, ".instret"}, instret, exp_instret);
`endif
  endtask

  task automatic model_reset();
    exp_pc      = RESET_PC;
    exp_ir      = NOP;
    exp_mepc    = '0;
    exp_mcause  = '0;
    exp_instret = '0;
  endtask

  task automatic clear_inputs();
    dec_illegal = 1'b0;
    unit_req    = '0;
    unit_busy   = '0;
    jal_jump    = 1'b0;
    jalr_jump   = 1'b0;
    take_branch = 1'b0;
    imm         = '0;
    jalr_base   = '0;
  endtask

  // one trap cycle followed by the first cycle of the trap handler fetch
  task automatic do_trap(input logic [3:0] code);
    chk("trap.state", 64'(state), 64'd5);
    strobes("trap", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    exp_mepc   = exp_pc;
    exp_mcause = code;
    exp_pc     = TRAP_VEC;
    chk("trap.next_state", 64'(state), 64'd0);
    chk("trap.next_addr", 64'(imem_addr), 64'(TRAP_VEC));
    strobes("trap.next", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    arch("trap.next");
  endtask

  // one instruction, entered and left in the FETCH state
  task automatic run_instr(input int fdly, input logic illegal, input logic [1:0] ureq,
                           input int bcyc, input logic jr, input logic jl, input logic br,
                           input logic [31:0] imm_v, input logic [31:0] base_v);
    logic [31:0] word;
    logic [31:0] tgt;
    logic        cf;
    logic        mis;
    logic [1:0]  outside;
    word = $urandom;
    cf   = jr | jl | br;
    if (jr)            tgt = (base_v + imm_v) & 32'hFFFF_FFFE;
    else if (jl || br) tgt = exp_pc + imm_v;
    else               tgt = exp_pc + 32'd4;
    mis = cf && tgt[1];

    // FETCH, optionally waiting for the instruction memory
    imem_valid = 1'b0;
    for (int i = 0; i < fdly; i++) begin
      chk("fetch_wait.state", 64'(state), 64'd0);
      chk("fetch_wait.addr", 64'(imem_addr), 64'(exp_pc));
      chk("fetch_wait.ir", 64'(ir), 64'(exp_ir));
      strobes("fetch_wait", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step();
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    chk("fetch.state", 64'(state), 64'd0);
    chk("fetch.addr", 64'(imem_addr), 64'(exp_pc));
    strobes("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    exp_ir = word;

    // DECODE
    dec_illegal = illegal;
    unit_req    = ureq;
    jalr_jump   = jr;
    jal_jump    = jl;
    take_branch = br;
    imm         = imm_v;
    jalr_base   = base_v;
    #1;
    chk("decode.state", 64'(state), 64'd1);
    chk("decode.ir", 64'(ir), 64'(exp_ir));
    strobes("decode", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    step();

    if (illegal) begin
      do_trap(4'd2);
    end else begin
      // EXECUTE
      chk("exec.state", 64'(state), 64'd2);
      strobes("exec", 1'b0, 1'b1, 1'b0, 1'b0, mis ? 2'b00 : ureq);
      outside = ~ureq & 2'($urandom_range(0, 3));
      if (!mis && ureq != 2'b00) unit_busy = ureq | outside;
      step();
      if (mis) begin
        do_trap(4'd0);
      end else begin
        if (ureq != 2'b00) begin
          for (int i = 0; i < bcyc; i++) begin
            chk("uwait.state", 64'(state), 64'd4);
            strobes("uwait", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            step();
          end
          unit_busy = outside;
          chk("uwait_last.state", 64'(state), 64'd4);
          strobes("uwait_last", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
          step();
        end
        // WRITE_BACK
        chk("wb.state", 64'(state), 64'd3);
        strobes("wb", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step();
        exp_pc      = tgt;
        exp_instret = exp_instret + 64'd1;
        chk("wb.next_state", 64'(state), 64'd0);
        chk("wb.next_addr", 64'(imem_addr), 64'(exp_pc));
        arch("wb.next");
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    clear_inputs();
    model_reset();

    // reset state
    step();
    step();
    chk("reset.state", 64'(state), 64'd0);
    strobes("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    arch("reset");
    reset = 1'b1;
    #1;
    chk("release.imem_req", 64'(imem_req), 64'd1);
    chk("release.addr", 64'(imem_addr), 64'(RESET_PC));

    // straight-line stream: pc 0,4,8 then a delayed fetch, up to pc 0x20
    for (int n = 0; n < 3; n++) run_instr(0, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_instr(3, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int n = 0; n < 4; n++) run_instr(0, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("at_0x20.pc", 64'(pc), 64'h20);

    // illegal instruction at 0x20
    run_instr(0, 1'b1, 2'b00, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("illegal.mepc", 64'(mepc), 64'h20);
    chk("illegal.mcause", 64'(mcause), 64'd2);

    // single unit, busy for five cycles after start
    run_instr(0, 1'b0, 2'b01, 5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    // both units launched together
    run_instr(1, 1'b0, 2'b11, 2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // jalr clears bit 0, then a misaligned jal traps with cause 0
    run_instr(0, 1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h41);
    chk("jalr.pc", 64'(pc), 64'h40);
    run_instr(0, 1'b0, 2'b01, 0, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
    chk("jal_mis.mcause", 64'(mcause), 64'd0);
    chk("jal_mis.mepc", 64'(mepc), 64'h40);
    // pc wraps modulo 2^32
    run_instr(0, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FE00, 32'h0);

    // randomized stream
    for (int n = 0; n < 80; n++) begin
      int          k;
      logic        jr;
      logic        jl;
      logic        br;
      logic [31:0] iv;
      k  = int'($urandom_range(0, 4));
      jr = (k == 2);
      jl = (k == 3) || (jr && $urandom_range(0, 1) == 1);
      br = (k == 4) || (k != 4 && k >= 2 && $urandom_range(0, 1) == 1);
      iv = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) iv[1] = 1'b1;
      run_instr(int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                2'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                jr, jl, br, iv, $urandom);
    end

    // reset in the middle of UNIT_WAIT
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    step();
    unit_req = 2'b01;
    step();
    unit_busy = 2'b01;
    chk("rst_uw.start", 64'(unit_start), 64'd1);
    step();
    chk("rst_uw.wait_state", 64'(state), 64'd4);
    step();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_uw.state", 64'(state), 64'd0);
    strobes("rst_uw", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    arch("rst_uw");
    step();
    strobes("rst_uw_hold", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    unit_req = 2'b00;
    reset    = 1'b1;
    #1;
    chk("rst_uw.release_req", 64'(imem_req), 64'd1);
    run_instr(0, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_instr(0, 1'b0, 2'b10, 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // reset in the middle of a stalled FETCH
    imem_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_fetch.state", 64'(state), 64'd0);
    strobes("rst_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    arch("rst_fetch");
    step();
    reset = 1'b1;
    #1;
    run_instr(0, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, sets datapath and PC width.
REQ-002 Parameter RESET_PC, default 0, sets PC value after reset.
REQ-003 Parameter TRAP_VEC, default 32'h100, sets PC loaded on any trap.
REQ-004 Parameter N_UNITS, default 2 (range 1..8), sets the number of multi-cycle unit handshake lanes.
REQ-005 Port list, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (equals pc).
- imem_valid  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- ir  out  32  instruction register.
- dec_illegal  in  1  decoder illegal-instruction flag.
- unit_req  in  N_UNITS  decoder: instruction needs unit i.
- unit_start  out  N_UNITS  unit launch pulse.
- unit_busy  in  N_UNITS  unit busy.
- jal_jump, jalr_jump, take_branch  in  1 each  control-flow selects.
- imm  in  XLEN  decoded immediate.
- jalr_base  in  XLEN  rs1 value.
- exec_en  out  1  EXECUTE strobe (result capture).
- wb_en  out  1  WRITE_BACK strobe (regfile write enable).
- pc  out  XLEN  current PC.
- state  out  3  current state.
- trap_taken  out  1  one-cycle trap pulse.
- mepc  out  XLEN  PC of trapping instruction.
- mcause  out  4  trap cause.

Function
REQ-006 States/encodings: FETCH 000, DECODE 001, EXECUTE 010, WRITE_BACK 011, UNIT_WAIT 100, TRAP 101; other codes go to TRAP next cycle.
REQ-007 FETCH: imem_req=1, imem_addr=pc; hold until imem_valid=1, then load ir<=imem_rdata, go to DECODE; no timeout.
REQ-008 DECODE: dec_illegal=1 -> TRAP, mcause=2; else -> EXECUTE.
REQ-009 EXECUTE: exec_en=1 for exactly one cycle.
- If the control-flow target has bit 1 set, go to TRAP, mcause=0. No unit_start, no wb_en. Check has priority over unit launch.
- Else if unit_req!=0: unit_start=unit_req this cycle only, latch launch mask, go to UNIT_WAIT.
- Else go to WRITE_BACK.
REQ-010 Multiple unit_req bits set SHALL launch all of them together; UNIT_WAIT waits for all.
REQ-011 UNIT_WAIT: minimum one cycle; exit to WRITE_BACK in the first cycle where (unit_busy & mask)==0; busy bits outside the mask are ignored.
REQ-012 WRITE_BACK: wb_en=1 for one cycle; pc<=pc_next; go to FETCH.
REQ-013 pc_next priority:
- jalr_jump: (jalr_base+imm) with bit0 cleared.
- else jal_jump or take_branch: pc+imm.
- else pc+4.
- All arithmetic modulo 2^XLEN, wrap silently.
REQ-014 TRAP: one cycle; mepc<=pc, mcause<=code, pc<=TRAP_VEC, trap_taken=1; go to FETCH; no wb_en.
REQ-015 exec_en, wb_en, unit_start, imem_req and trap_taken SHALL be 0 outside their stated states.
REQ-016 Each non-trapping instruction takes exactly 4 cycles with no waits: FETCH (valid same cycle), DECODE, EXECUTE, WRITE_BACK.

Reset
REQ-017 While reset=0, regardless of current state:
- state=FETCH, pc=RESET_PC, ir=32'h00000013, mepc=0, mcause=0.
- imem_req and all strobe outputs held 0.
REQ-018 Reset asserted mid-UNIT_WAIT or mid-FETCH SHALL abandon the operation; the launch mask clears and no wb_en follows.
REQ-019 First imem_req SHALL occur in the first clk edge cycle after reset deasserts.

Configuration
REQ-020 With macro MC_SEQ_INSTRET_EN defined:
- add output instret (64 bits), reset 0.
- instret increments by 1 on each WRITE_BACK cycle, never on TRAP, and wraps at 2^64.
REQ-021 Without MC_SEQ_INSTRET_EN, the instret port and counter are absent.

Verification
REQ-022 Reset release, imem_valid tied 1, ADDI stream -> pc 0,4,8 with wb_en every 4th cycle.
REQ-023 imem_valid delayed 3 cycles -> FETCH held 4 cycles, imem_addr stable, ir updates once.
REQ-024 unit_req=2'b01, unit_busy[0] high 5 cycles after start -> unit_start 1 cycle, wb_en 1 cycle after busy falls.
REQ-025 dec_illegal=1 at pc=0x20 -> trap_taken=1, mepc=0x20, mcause=2, next imem_addr=0x100, no wb_en.
REQ-026 jalr_base=0x41, imm=0, jalr_jump=1 -> pc becomes 0x40. With jal_jump=1 and imm=0x6 -> TRAP, mcause=0.
REQ-027 reset=0 asserted mid-UNIT_WAIT -> state=FETCH, pc=RESET_PC at once; MC_SEQ_INSTRET_EN build shows instret=0.
